// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: access-size and grant encodings shared by the RAM port arbiter
package ram_arb_pkg;
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam int LANES = 4;
    typedef enum logic {PORT_I = 1'b0, PORT_D = 1'b1} port_e;
endpackage

// File: rtl/ram_lane_align.sv
// ram_lane_align: byte enables, write lane shift, read shift/extend and alignment check
module ram_lane_align
    import ram_arb_pkg::*;
(
    input  logic [1:0]       off,
    input  logic [1:0]       size,
    input  logic             we,
    input  logic             zext,
    input  logic [31:0]      wdata,
    input  logic [31:0]      dout,
    output logic [LANES-1:0] be,
    output logic [31:0]      din,
    output logic [31:0]      rdata,
    output logic             err
);
    logic [LANES-1:0] be_base;
    logic [31:0]      sh;
    // Faulty accesses read all lanes without writing and return zero data
    always_comb begin
        err     = size == SIZE_B ? 1'b0 : size == SIZE_H ? off[0] : size == SIZE_W ? |off : 1'b1;
        be_base = size == SIZE_B ? 4'b0001 : size == SIZE_H ? 4'b0011 : 4'b1111;
        be      = we && !err ? be_base << off : 4'b1111;
        din     = wdata << {off, 3'b000};
        sh      = dout >> {off, 3'b000};
        rdata   = err || we ? '0
                : size == SIZE_B ? {{24{!zext && sh[7]}}, sh[7:0]}
                : size == SIZE_H ? {{16{!zext && sh[15]}}, sh[15:0]}
                : sh;
    end
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one byte-enabled RAM between fetch (I) and load/store (D); RAM_ARB_RR_EN selects round-robin
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_STREAK = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  i_req_valid_i,
    output logic                  i_req_ready_o,
    input  logic [ADDR_WIDTH-1:0] i_addr_i,
    output logic                  i_rsp_valid_o,
    output logic [DATA_WIDTH-1:0] i_rsp_rdata_o,
    output logic                  i_rsp_err_o,
    input  logic                  d_req_valid_i,
    output logic                  d_req_ready_o,
    input  logic [ADDR_WIDTH-1:0] d_addr_i,
    input  logic                  d_we_i,
    input  logic [1:0]            d_size_i,
    input  logic                  d_unsigned_i,
    input  logic [DATA_WIDTH-1:0] d_wdata_i,
    output logic                  d_rsp_valid_o,
    output logic [DATA_WIDTH-1:0] d_rsp_rdata_o,
    output logic                  d_rsp_err_o,
    output logic [ADDR_WIDTH-3:0] ram_addr_o,
    output logic [DATA_WIDTH-1:0] ram_din_o,
    output logic                  ram_we_o,
    output logic [LANES-1:0]      ram_be_o,
    input  logic [DATA_WIDTH-1:0] ram_dout_i
);
    logic                  gnt_i, gnt_d, any, err;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           rdata;
    logic [LANES-1:0]      be;
    port_e                 sel;
`ifdef RAM_ARB_RR_EN
    port_e ptr;
    // The pointer only decides when both ports ask in the same cycle
    always_comb begin
        gnt_i = i_req_valid_i && (!d_req_valid_i || ptr == PORT_I);
        gnt_d = d_req_valid_i && (!i_req_valid_i || ptr == PORT_D);
    end
    // After a contested grant the loser gets priority next time
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) ptr <= PORT_I;
        else if (i_req_valid_i && d_req_valid_i) ptr <= gnt_i ? PORT_D : PORT_I;
`else
    localparam int SW = $clog2(MAX_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);
    logic [SW-1:0] streak;
    // D wins unless it has already starved a waiting fetch MAX_STREAK times
    always_comb begin
        gnt_d = d_req_valid_i && (!i_req_valid_i || streak != STREAK_MAX);
        gnt_i = i_req_valid_i && !gnt_d;
    end
    // Count D grants made while a fetch is waiting
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) streak <= '0;
        else if (!i_req_valid_i || gnt_i) streak <= '0;
        else if (gnt_d) streak <= streak + 1'b1;
`endif
    // Route the granted port onto the RAM; an idle cycle drives zeros
    always_comb begin
        sel           = gnt_d ? PORT_D : PORT_I;
        any           = gnt_i || gnt_d;
        addr          = sel == PORT_D ? d_addr_i : i_addr_i;
        i_req_ready_o = gnt_i;
        d_req_ready_o = gnt_d;
        ram_addr_o    = any ? addr[ADDR_WIDTH-1:2] : '0;
        ram_be_o      = any ? be : '0;
        ram_we_o      = gnt_d && d_we_i && !err;
    end
    ram_lane_align u_align (
        .off   (addr[1:0]),
        .size  (sel == PORT_D ? d_size_i : SIZE_W),
        .we    (sel == PORT_D && d_we_i),
        .zext  (sel == PORT_D ? d_unsigned_i : 1'b1),
        .wdata (d_wdata_i),
        .dout  (ram_dout_i),
        .be    (be),
        .din   (ram_din_o),
        .rdata (rdata),
        .err   (err)
    );
    // Responses appear exactly one cycle after the grant; reset drops them
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            i_rsp_valid_o <= 1'b0;
            i_rsp_err_o   <= 1'b0;
            i_rsp_rdata_o <= '0;
            d_rsp_valid_o <= 1'b0;
            d_rsp_err_o   <= 1'b0;
            d_rsp_rdata_o <= '0;
        end else begin
            i_rsp_valid_o <= gnt_i;
            i_rsp_err_o   <= gnt_i && err;
            i_rsp_rdata_o <= gnt_i ? rdata : '0;
            d_rsp_valid_o <= gnt_d;
            d_rsp_err_o   <= gnt_d && err;
            d_rsp_rdata_o <= gnt_d ? rdata : '0;
        end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed stimulus against a byte-level memory/arbitration model
module tb_ram_port_arbiter;
    localparam int MAX = 4;
    logic        clk = 0, rst_n = 0;
    logic        iv, i_ready, i_rsp_valid, i_rsp_err;
    logic [11:0] ia, da;
    logic [31:0] i_rsp_rdata, d_rsp_rdata, dwd, ram_din, ram_dout;
    logic        dv, d_ready, dwe, dun, d_rsp_valid, d_rsp_err, ram_we;
    logic [1:0]  dsz;
    logic [9:0]  ram_addr;
    logic [3:0]  ram_be;
    logic [31:0] ram [0:1023];
    logic [7:0]  refm [0:4095];
    bit          ram_init = 0, refm_init = 0;
    int          errs = 0, checks = 0, run = 0;
    bit          turn = 0;
    logic        p_iv = 0, p_ie = 0, p_dv = 0, p_de = 0;
    logic [31:0] p_ir = 0, p_dr = 0;
    logic        exp_g [10];

    always #5 clk = ~clk;

    ram_port_arbiter dut (
        .clk_i(clk), .rst_ni(rst_n),
        .i_req_valid_i(iv), .i_req_ready_o(i_ready), .i_addr_i(ia),
        .i_rsp_valid_o(i_rsp_valid), .i_rsp_rdata_o(i_rsp_rdata), .i_rsp_err_o(i_rsp_err),
        .d_req_valid_i(dv), .d_req_ready_o(d_ready), .d_addr_i(da), .d_we_i(dwe),
        .d_size_i(dsz), .d_unsigned_i(dun), .d_wdata_i(dwd),
        .d_rsp_valid_o(d_rsp_valid), .d_rsp_rdata_o(d_rsp_rdata), .d_rsp_err_o(d_rsp_err),
        .ram_addr_o(ram_addr), .ram_din_o(ram_din), .ram_we_o(ram_we), .ram_be_o(ram_be),
        .ram_dout_i(ram_dout)
    );

    function automatic logic [31:0] pat(input int w);
        return 32'(w) * 32'h9E3779B1;
    endfunction

    // Environment RAM: combinational read, byte-enabled write at the clock edge
    assign ram_dout = ram[ram_addr];
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int w = 0; w < 1024; w++) ram[w] <= pat(w);
            ram_init <= 1;
        end else if (ram_we)
            for (int b = 0; b < 4; b++) if (ram_be[b]) ram[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: byte memory plus arbitration rules, checked every negedge
    always @(negedge clk) begin
        logic gi, gd, derr, ierr;
        int n, off;
        logic [31:0] v, m, wexp;
        if (!refm_init) begin
            for (int w = 0; w < 1024; w++) begin
                v = pat(w);
                for (int k = 0; k < 4; k++) refm[4*w+k] = v[8*k +: 8];
            end
            refm_init = 1;
        end
        if (!rst_n) begin
            chk("rst i_rsp_valid", {31'd0, i_rsp_valid}, 0);
            chk("rst i_rsp_err", {31'd0, i_rsp_err}, 0);
            chk("rst i_rsp_rdata", i_rsp_rdata, 0);
            chk("rst d_rsp_valid", {31'd0, d_rsp_valid}, 0);
            chk("rst d_rsp_err", {31'd0, d_rsp_err}, 0);
            chk("rst d_rsp_rdata", d_rsp_rdata, 0);
            p_iv = 0; p_dv = 0; run = 0; turn = 0;
        end else begin
            chk("i_rsp_valid", {31'd0, i_rsp_valid}, {31'd0, p_iv});
            if (p_iv) begin
                chk("i_rsp_err", {31'd0, i_rsp_err}, {31'd0, p_ie});
                chk("i_rsp_rdata", i_rsp_rdata, p_ir);
            end
            chk("d_rsp_valid", {31'd0, d_rsp_valid}, {31'd0, p_dv});
            if (p_dv) begin
                chk("d_rsp_err", {31'd0, d_rsp_err}, {31'd0, p_de});
                chk("d_rsp_rdata", d_rsp_rdata, p_dr);
            end
`ifdef RAM_ARB_RR_EN
            if (iv && dv) begin
                gi = !turn; gd = turn; turn = !turn;
            end else begin
                gi = iv; gd = dv;
            end
`else
            gd = dv && (!iv || run < MAX);
            gi = iv && !gd;
            run = (!iv || gi) ? 0 : run + 1;
`endif
            chk("i_ready", {31'd0, i_ready}, {31'd0, gi});
            chk("d_ready", {31'd0, d_ready}, {31'd0, gd});
            p_iv = gi; p_dv = gd; p_ie = 0; p_de = 0; p_ir = 0; p_dr = 0;
            if (!gi && !gd) begin
                chk("idle ram_we", {31'd0, ram_we}, 0);
                chk("idle ram_be", {28'd0, ram_be}, 0);
                chk("idle ram_addr", {22'd0, ram_addr}, 0);
            end
            if (gi) begin
                ierr = ia[1:0] != 0;
                chk("i ram_addr", {22'd0, ram_addr}, 32'(ia / 4));
                chk("i ram_we", {31'd0, ram_we}, 0);
                if (!ierr) chk("i ram_be", {28'd0, ram_be}, 32'hF);
                p_ie = ierr;
                if (!ierr) for (int k = 0; k < 4; k++) p_ir[8*k +: 8] = refm[ia+k];
            end
            if (gd) begin
                n = dsz == 0 ? 1 : dsz == 1 ? 2 : 4;
                off = int'(da[1:0]);
                derr = dsz == 3 || (off % n) != 0;
                p_de = derr;
                chk("d ram_addr", {22'd0, ram_addr}, 32'(da / 4));
                if (derr || !dwe) chk("d ram_we", {31'd0, ram_we}, 0);
                if (!derr && dwe) begin
                    m = 0; wexp = 0;
                    for (int k = 0; k < n; k++) begin
                        m[8*(off+k) +: 8] = 8'hFF;
                        wexp[8*(off+k) +: 8] = dwd[8*k +: 8];
                        refm[da+k] = dwd[8*k +: 8];
                    end
                    chk("d store ram_we", {31'd0, ram_we}, 1);
                    chk("d store ram_be", {28'd0, ram_be}, {28'd0, m[24], m[16], m[8], m[0]});
                    chk("d store ram_din", ram_din & m, wexp);
                end else if (!derr) begin
                    chk("d load ram_be", {28'd0, ram_be}, 32'hF);
                    v = 0;
                    for (int k = 0; k < n; k++) v[8*k +: 8] = refm[da+k];
                    if (!dun && n < 4 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8*n));
                    p_dr = v;
                end
            end
        end
    end

    task automatic idle();
        iv = 0; ia = 0; dv = 0; da = 0; dwe = 0; dsz = 0; dun = 0; dwd = 0;
    endtask
    task automatic tick();
        @(posedge clk); #1; idle();
    endtask
    task automatic dreq(input logic [11:0] a, input logic we, input logic [1:0] sz, input logic un, input logic [31:0] wd);
        dv = 1; da = a; dwe = we; dsz = sz; dun = un; dwd = wd;
    endtask
    task automatic ireq(input logic [11:0] a);
        iv = 1; ia = a;
    endtask

    initial begin
        idle();
        for (int i = 0; i < 10; i++)
`ifdef RAM_ARB_RR_EN
            exp_g[i] = (i % 2) == 1;
`else
            exp_g[i] = (i % 5) != 4;
`endif
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        tick();
        // store word, load top byte unsigned
        dreq(12'h010, 1, 2'b10, 0, 32'hDEADBEEF); tick();
        dreq(12'h013, 0, 2'b00, 1, 0); tick();
        chk("t1 valid", {31'd0, d_rsp_valid}, 1);
        chk("t1 rdata", d_rsp_rdata, 32'h000000DE);
        chk("t1 err", {31'd0, d_rsp_err}, 0);
        // half store on upper lanes, signed half load
        dreq(12'h022, 1, 2'b01, 0, 32'h0000A55A); #1;
        chk("t2 be", {28'd0, ram_be}, 32'hC);
        chk("t2 din", ram_din, 32'hA55A0000);
        tick();
        dreq(12'h022, 0, 2'b01, 0, 0); tick();
        chk("t2 rdata", d_rsp_rdata, 32'hFFFFA55A);
        // misaligned word load, then a normal store/load
        dreq(12'h006, 0, 2'b10, 0, 0); #1;
        chk("t3 we", {31'd0, ram_we}, 0);
        tick();
        chk("t3 err", {31'd0, d_rsp_err}, 1);
        chk("t3 rdata", d_rsp_rdata, 0);
        dreq(12'h004, 1, 2'b10, 0, 32'hCAFEF00D); tick();
        dreq(12'h004, 0, 2'b10, 0, 0); tick();
        chk("t3 reload", d_rsp_rdata, 32'hCAFEF00D);
        // illegal size store is rejected without writing
        dreq(12'h008, 1, 2'b11, 0, 32'hFFFFFFFF); #1;
        chk("ill we", {31'd0, ram_we}, 0);
        tick();
        chk("ill err", {31'd0, d_rsp_err}, 1);
        dreq(12'h008, 0, 2'b10, 0, 0); tick();
        tick();
        // fetch side: misaligned and aligned
        ireq(12'h002); tick();
        chk("i misaligned err", {31'd0, i_rsp_err}, 1);
        ireq(12'h010); tick();
        chk("i fetch", i_rsp_rdata, 32'hDEADBEEF);
        dreq(12'h031, 1, 2'b00, 0, 32'h00000080); tick();
        dreq(12'h031, 0, 2'b00, 0, 0); tick();
        tick();
        // contention pattern
        for (int i = 0; i < 10; i++) begin
            ireq(12'(4 * i));
            dreq(12'(12'h100 + i), 0, 2'b00, i[0], 0);
            #1 chk($sformatf("t4 grant %0d", i), {31'd0, d_ready}, {31'd0, exp_g[i]});
            tick();
        end
        tick();
        // back-to-back store/load to one word
        dreq(12'h040, 1, 2'b10, 0, 32'h12345678); tick();
        dreq(12'h040, 0, 2'b10, 0, 0); tick();
        chk("t5 word", d_rsp_rdata, 32'h12345678);
        dreq(12'h041, 1, 2'b00, 0, 32'h00000099); tick();
        dreq(12'h040, 0, 2'b01, 0, 0); tick();
        chk("t5 half", d_rsp_rdata, 32'hFFFF9978);
        // reset with a response in flight
        dreq(12'h010, 0, 2'b10, 0, 0); tick();
        chk("t6 before rst", {31'd0, d_rsp_valid}, 1);
        #2 rst_n = 0;
        #1 chk("t6 dropped", {31'd0, d_rsp_valid}, 0);
        chk("t6 rdata", d_rsp_rdata, 0);
        @(posedge clk); #1 rst_n = 1;
        tick();
        chk("t6 after rel", {31'd0, d_rsp_valid}, 0);
        tick();
        chk("t6 after rel2", {31'd0, d_rsp_valid}, 0);
        ireq(12'h010); dreq(12'h010, 0, 2'b10, 0, 0); tick();
        ireq(12'h010); dreq(12'h010, 0, 2'b10, 0, 0); tick();
        tick();
        tick();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
